// File: rtl/cam_sliced_if.sv
// Request/lookup bundle for the sliced CAM.
// Master drives requests and lookups; slave returns status and results.
interface cam_sliced_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    localparam int N = 1 << ADDR_WIDTH;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  del_en;
    logic [ADDR_WIDTH-1:0] del_addr;
    logic                  clr_en;
    logic                  busy;
    logic                  lu_valid;
    logic [DATA_WIDTH-1:0] lu_data;
    logic                  lu_done;
    logic [N-1:0]          lu_match;
    logic                  lu_hit;
    logic [ADDR_WIDTH-1:0] lu_addr;
    logic                  lu_multi;

    modport master (
        output wr_en, wr_addr, wr_data,
        output del_en, del_addr, clr_en,
        output lu_valid, lu_data,
        input  busy, lu_done, lu_match,
        input  lu_hit, lu_addr, lu_multi
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  del_en, del_addr, clr_en,
        input  lu_valid, lu_data,
        output busy, lu_done, lu_match,
        output lu_hit, lu_addr, lu_multi
    );
endinterface

// File: rtl/cam_sliced.sv
// RAM-based CAM with per-slice transposed tables, valid tracking,
// sequential flush and a two-stage priority-encoded lookup.
module cam_sliced #(
    parameter int DATA_WIDTH  = 16,
    parameter int SLICE_WIDTH = 8,
    parameter int ADDR_WIDTH  = 3
) (
    input logic         clk,
    input logic         rst,
    cam_sliced_if.slave bus
);
    localparam int N    = 1 << ADDR_WIDTH;
    localparam int NS   = DATA_WIDTH / SLICE_WIDTH;
    localparam int ROWS = 1 << SLICE_WIDTH;

    typedef logic [SLICE_WIDTH-1:0] row_t;
    typedef logic [N-1:0]           col_t;
    typedef logic [DATA_WIDTH-1:0]  key_t;
    typedef logic [ADDR_WIDTH-1:0]  addr_t;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WR_CLR,
        S_WR_SET,
        S_DEL,
        S_FLUSH
    } state_t;

    state_t state, state_nxt;
    row_t   cnt;
    addr_t  op_addr;
    key_t   op_data;
    col_t   vld;
    key_t   key [N];
    col_t   tbl [NS][ROWS];

    logic acc_clr, acc_wr, acc_del;
    logic sweeping, do_clr, do_set;

    function automatic row_t slice_of(input key_t k, input int s);
        return k[s*SLICE_WIDTH +: SLICE_WIDTH];
    endfunction

    assign sweeping = (state == S_INIT) || (state == S_FLUSH);
    assign do_set   = (state == S_WR_SET);
    assign do_clr   = ((state == S_WR_CLR) || (state == S_DEL))
                      && vld[op_addr];
    assign bus.busy = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        acc_wr    = 1'b0;
        acc_del   = 1'b0;
        unique case (state)
            S_INIT, S_FLUSH: begin
                if (cnt == row_t'(ROWS - 1))
                    state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (bus.clr_en) begin
                    acc_clr   = 1'b1;
                    state_nxt = S_FLUSH;
                end else if (bus.wr_en) begin
                    acc_wr    = 1'b1;
                    state_nxt = S_WR_CLR;
                end else if (bus.del_en) begin
                    acc_del   = 1'b1;
                    state_nxt = S_DEL;
                end
            end
            S_WR_CLR: state_nxt = S_WR_SET;
            S_WR_SET: state_nxt = S_IDLE;
            S_DEL:    state_nxt = S_IDLE;
            default:  state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_INIT;
            cnt     <= '0;
            op_addr <= '0;
            op_data <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= sweeping ? cnt + 1'b1 : '0;
            if (acc_wr) begin
                op_addr <= bus.wr_addr;
                op_data <= bus.wr_data;
            end else if (acc_del) begin
                op_addr <= bus.del_addr;
            end
        end
    end

    // Shadow keys let a rewrite or delete find the rows to clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
            for (int i = 0; i < N; i++)
                key[i] <= '0;
        end else begin
            if (sweeping || acc_clr)
                vld <= '0;
            else if (do_set) begin
                vld[op_addr] <= 1'b1;
                key[op_addr] <= op_data;
            end else if (do_clr && state == S_DEL)
                vld[op_addr] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < NS; s++) begin
            unique case (1'b1)
                sweeping:
                    tbl[s][cnt] <= '0;
                do_clr:
                    tbl[s][slice_of(key[op_addr], s)][op_addr] <= 1'b0;
                do_set:
                    tbl[s][slice_of(op_data, s)][op_addr] <= 1'b1;
                default: ;
            endcase
        end
    end

    col_t rd [NS];
    col_t vsnap;
    logic inh;
    logic s1_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NS; s++)
                rd[s] <= '0;
            vsnap  <= '0;
            inh    <= 1'b0;
            s1_vld <= 1'b0;
        end else begin
            for (int s = 0; s < NS; s++)
                rd[s] <= tbl[s][slice_of(bus.lu_data, s)];
            vsnap  <= vld;
            inh    <= sweeping;
            s1_vld <= bus.lu_valid;
        end
    end

    col_t  m;
    addr_t lo;
    logic  found;

    always_comb begin
        m = vsnap & ~{N{inh}};
        for (int s = 0; s < NS; s++)
            m = m & rd[s];
        lo    = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m[i] && !found) begin
                lo    = addr_t'(i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.lu_done  <= 1'b0;
            bus.lu_match <= '0;
            bus.lu_hit   <= 1'b0;
            bus.lu_addr  <= '0;
            bus.lu_multi <= 1'b0;
        end else begin
            bus.lu_done <= s1_vld;
            if (s1_vld) begin
                bus.lu_match <= m;
                bus.lu_hit   <= found;
                bus.lu_addr  <= lo;
                bus.lu_multi <= |(m & (m - 1'b1));
            end
        end
    end
endmodule

// File: tb/tb_cam_sliced.sv
// Directed bench for cam_sliced: reference key/valid model feeds
// a result queue that is drained whenever lu_done is seen.
module tb_cam_sliced;
    localparam int AW = 3;
    localparam int DW = 16;
    localparam int N  = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    cam_sliced_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    cam_sliced #(
        .DATA_WIDTH (DW),
        .SLICE_WIDTH(8),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [N-1:0]  m;
        logic          hit;
        logic [AW-1:0] a;
        logic          multi;
    } res_t;

    res_t          sbq [$];
    res_t          last;
    logic [DW-1:0] mk [N];
    logic [N-1:0]  mv;
    int            vec = 0;
    int            err = 0;
    int            n;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [DW-1:0] k, input bit inh);
        res_t r;
        int   c;
        r = '0;
        c = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mv[i] && mk[i] == k && !inh) begin
                r.m[i] = 1'b1;
                r.a    = AW'(i);
                c++;
            end
        end
        r.hit   = (c > 0);
        r.multi = (c > 1);
        return r;
    endfunction

    task automatic step();
        res_t e;
        @(posedge clk);
        #1;
        if (bus.lu_done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("spurious_done", {31'd0, bus.lu_done}, 32'd0);
            end else begin
                e    = sbq.pop_front();
                last = e;
                chk("lu_match", {24'd0, bus.lu_match}, {24'd0, e.m});
                chk("lu_hit", {31'd0, bus.lu_hit}, {31'd0, e.hit});
                chk("lu_addr", {29'd0, bus.lu_addr}, {29'd0, e.a});
                chk("lu_multi", {31'd0, bus.lu_multi}, {31'd0, e.multi});
            end
        end
    endtask

    task automatic lookup(input logic [DW-1:0] k);
        bus.lu_valid = 1'b1;
        bus.lu_data  = k;
        sbq.push_back(model(k, 1'b0));
        step();
        bus.lu_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 6 && sbq.size() > 0; i++)
            step();
        chk("queue_empty", sbq.size(), 32'd0);
        sbq.delete();
    endtask

    task automatic lookup1(input logic [DW-1:0] k);
        lookup(k);
        step();
        chk("lu_latency", {31'd0, bus.lu_done}, 32'd1);
        drain();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
        chk("wr_busy", {31'd0, bus.busy}, 32'd1);
        step();
        step();
        chk("wr_idle", {31'd0, bus.busy}, 32'd0);
        mk[a] = d;
        mv[a] = 1'b1;
    endtask

    task automatic del(input logic [AW-1:0] a);
        bus.del_en   = 1'b1;
        bus.del_addr = a;
        step();
        bus.del_en = 1'b0;
        chk("del_busy", {31'd0, bus.busy}, 32'd1);
        step();
        chk("del_idle", {31'd0, bus.busy}, 32'd0);
        mv[a] = 1'b0;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 400) begin
            cnt++;
            step();
        end
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        chk({tag, "_done"}, {31'd0, bus.lu_done}, 32'd0);
        chk({tag, "_match"}, {24'd0, bus.lu_match}, 32'd0);
        chk({tag, "_hit"}, {31'd0, bus.lu_hit}, 32'd0);
        chk({tag, "_addr"}, {29'd0, bus.lu_addr}, 32'd0);
        chk({tag, "_multi"}, {31'd0, bus.lu_multi}, 32'd0);
    endtask

    initial begin
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.del_en   = 1'b0;
        bus.del_addr = '0;
        bus.clr_en   = 1'b0;
        bus.lu_valid = 1'b0;
        bus.lu_data  = '0;
        mv           = '0;
        last         = '0;
        for (int i = 0; i < N; i++)
            mk[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk_zero_outs("reset");

        // Init sweep with a lookup issued while tables are inhibited.
        rst = 1'b1;
        n   = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            bus.lu_valid = (n == 3);
            bus.lu_data  = 16'h1234;
            if (n == 3)
                sbq.push_back(model(16'h1234, 1'b1));
            n++;
            step();
        end
        bus.lu_valid = 1'b0;
        chk("init_cycles", n, 32'd256);
        drain();

        wr(3'd3, 16'h1234);
        lookup1(16'h1234);
        chk("a3_match", {24'd0, bus.lu_match}, 32'h08);

        wr(3'd3, 16'h5678);
        lookup1(16'h1234);
        lookup1(16'h5678);
        wr(3'd1, 16'h12FF);
        lookup1(16'h1278);
        lookup1(16'h12FF);

        wr(3'd2, 16'hAAAA);
        wr(3'd5, 16'hAAAA);
        lookup1(16'hAAAA);
        chk("dup_match", {24'd0, bus.lu_match}, 32'h24);
        del(3'd2);
        lookup1(16'hAAAA);
        del(3'd7);
        lookup1(16'hAAAA);

        // Back-to-back lookups, then results must hold.
        lookup(16'h5678);
        lookup(16'hAAAA);
        lookup(16'h12FF);
        drain();
        step();
        step();
        chk("hold_done", {31'd0, bus.lu_done}, 32'd0);
        chk("hold_match", {24'd0, bus.lu_match}, {24'd0, last.m});
        chk("hold_addr", {29'd0, bus.lu_addr}, {29'd0, last.a});

        // Flush beats a simultaneous write.
        bus.clr_en  = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd0;
        bus.wr_data = 16'hBEEF;
        step();
        bus.clr_en = 1'b0;
        bus.wr_en  = 1'b0;
        count_busy(n);
        chk("flush_cycles", n, 32'd256);
        mv = '0;
        lookup1(16'hBEEF);
        lookup1(16'h5678);
        lookup1(16'hAAAA);
        lookup1(16'h12FF);
        wr(3'd6, 16'hBEEF);
        lookup1(16'hBEEF);

        // Reset asserted in the middle of a write.
        wr(3'd4, 16'h4444);
        lookup1(16'h4444);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd4;
        bus.wr_data = 16'h4545;
        step();
        bus.wr_en = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk_zero_outs("midrst");
        mv = '0;
        repeat (2) step();
        rst = 1'b1;
        count_busy(n);
        chk("reinit_cycles", n, 32'd256);
        lookup1(16'h4444);
        lookup1(16'h4545);
        lookup1(16'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
